keypad_scan: RTL and testbench
==============================

// Module: keypad_scan
// PURPOSE
//  Front-panel input scanner for the clock/timer board; it is the read side of the
//  multiplexed panel, mirroring the 7-segment digit driver.
//  Drives a 4x4 matrix keypad one column at a time with active-low one-hot strobes,
//  samples the rows, debounces whole-matrix images and emits a single-key press event.
//  Feeds key codes to the time-set / mode control logic.
// PARAMETERS
//  SCAN_TICKS  1000  clock cycles each column is driven; must be >= 4
//  DB_SCANS    4     consecutive identical full sweeps required for a stable image; >= 2
// PORTS
//  clock      in   1  system clock, all logic on rising edge
//  reset      in   1  asynchronous, active-low reset
//  col        out  4  column strobes, active-low one-hot; col[0] = column 0
//  row        in   4  row returns, active-low (pulled up off-chip), asynchronous
//  key_code   out  4  code of last accepted key = row_index*4 + col_index
//  key_valid  out  1  one-cycle pulse when a new key press is accepted
//  key_held   out  1  high while the accepted key stays stably pressed alone
// BEHAVIOUR
//  Reset values: col=4'b1110, key_code=0, key_valid=0, key_held=0.
//   All counters, images and debounce count are 0; FSM is in NOKEY.
//  row passes a 2-flop synchronizer before any use.
//  Column dwell: tick counter runs 0..SCAN_TICKS-1 per column.
//   - On tick==SCAN_TICKS-1, ~row_sync is stored into snapshot[col_idx*4 +: 4].
//   - On the next edge, col rotates to the next column (0->1->2->3->0) and tick clears.
//   - A full sweep lasts 4*SCAN_TICKS cycles.
//   - The sweep ends on the sample cycle of column 3.
//  Debounce, evaluated at each sweep end:
//   - snapshot==prev: db_cnt saturates at DB_SCANS-1.
//   - snapshot!=prev: db_cnt=0 and prev=snapshot.
//   - When db_cnt reaches DB_SCANS-1, stable<=snapshot and stable_upd pulses.
//   - stable_upd pulses only on the increment that reaches DB_SCANS-1, not while saturated.
//  FSM (NOKEY, KEYDOWN, LOCKOUT) acts only on stable_upd.
//   - single = exactly one bit set in stable.
//   - NOKEY, single: latch key_code, pulse key_valid next cycle, go to KEYDOWN.
//   - NOKEY, 2+ bits set: go to LOCKOUT.
//   - NOKEY, zero: stay in NOKEY.
//   - KEYDOWN, zero: go to NOKEY.
//   - KEYDOWN, any other non-zero image (different key or multi-key): go to LOCKOUT, no event.
//   - LOCKOUT, zero: go to NOKEY; otherwise stay.
//  key_held=1 exactly while in KEYDOWN.
//  key_code holds its value until the next accepted key; it is not cleared on release.
//  Ghosting and multi-key images never produce an event; release and press again to re-arm.
//  Latency: a key pressed before a sweep starts yields key_valid
//   ~DB_SCANS*4*SCAN_TICKS + 2 cycles later.
//  Counter widths: tick uses $clog2(SCAN_TICKS) bits; db_cnt uses $clog2(DB_SCANS) bits.
//   Counters never wrap past their terminal value.
//  Reset asserted mid-sweep: all state returns to reset values immediately and asynchronously.
//   A pending key_valid is dropped. Scanning restarts at column 0.
// STRUCTURE
//  Shared panel package: NUM_COLS=4, NUM_ROWS=4, FSM state encoding (NOKEY/KEYDOWN/LOCKOUT),
//   col reset pattern 4'b1110.
//  One sub-module: keypad_debounce.
//   - Inputs: snapshot, sweep_end. Outputs: stable, stable_upd.
//   - Holds prev and db_cnt.
//  keypad_scan keeps the synchronizer, column/tick counters, snapshot assembly and FSM.
// TESTING  (bench uses SCAN_TICKS=4, DB_SCANS=3; sweep = 16 cycles)
//  1. No keys after reset release.
//     -> col cycles 1110,1101,1011,0111, each held 4 cycles; key_valid never asserts.
//  2. Key r2/c1 held from reset release.
//     -> one key_valid pulse at cycle 48+/-2; key_code=9; key_held=1 until release.
//     -> After release, key_held drops within 3 sweeps + 2 cycles; key_code stays 9.
//  3. Key r0/c3 bouncing (toggling every 5 cycles) for 40 cycles, then held.
//     -> exactly one key_valid, key_code=3, no pulse during the bounce.
//  4. Keys r1/c0 and r3/c2 pressed together.
//     -> no key_valid; FSM in LOCKOUT; release all, then press r1/c0 alone.
//     -> key_valid, key_code=4.
//  5. Key held; reset asserted low for 3 cycles at cycle 30.
//     -> outputs 0 and col=1110 at once.
//     -> After release, a fresh key_valid arrives ~48 cycles later with the same code.

Source files
------------

// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the front-panel keypad scanner.
// Holds the matrix geometry, the key-state encoding, the idle column pattern,
// and helpers that turn a sampled key image into a key code.
package keypad_scan_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;
  localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;

  // Column 0 is driven first after reset.
  localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

  typedef enum logic [1:0] {
    NOKEY   = 2'd0,
    KEYDOWN = 2'd1,
    LOCKOUT = 2'd2
  } kp_state_t;

  // Images are column-major: bit col*NUM_ROWS + row is set when that key is down.
  function automatic logic is_single(input logic [NUM_KEYS-1:0] img);
    return (img != '0) && ((img & (img - 16'd1)) == '0);
  endfunction

  // Key code is row*4 + col of the (single) set bit.
  function automatic logic [3:0] image_to_code(input logic [NUM_KEYS-1:0] img);
    logic [3:0] code;
    code = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      for (int r = 0; r < NUM_ROWS; r++) begin
        if (img[c*NUM_ROWS + r]) begin
          code = 4'(r * NUM_COLS + c);
        end
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Whole-image debouncer: accepts a key image after DB_SCANS identical sweeps in a row.
// Latency: stable/stable_upd update one cycle after the sweep_end that completes the run.
// Backpressure: none; stable_upd is a single-cycle pulse, consumer must take it when it fires.
// Ports: clock, reset (async active-low), snapshot (full image), sweep_end (image complete),
//        stable (last accepted image), stable_upd (pulse when stable is newly loaded).
module keypad_debounce
  import keypad_scan_pkg::*;
#(
  parameter int DB_SCANS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] snapshot,
  input  logic                sweep_end,
  output logic [NUM_KEYS-1:0] stable,
  output logic                stable_upd
);

  localparam int            CW      = $clog2(DB_SCANS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_SCANS - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [NUM_KEYS-1:0] prev;
  logic [CW-1:0]       db_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prev       <= '0;
      db_cnt     <= '0;
      stable     <= '0;
      stable_upd <= 1'b0;
    end else begin
      stable_upd <= 1'b0;
      if (sweep_end) begin
        if (snapshot != prev) begin
          prev   <= snapshot;
          db_cnt <= '0;
        end else if (db_cnt != CNT_MAX) begin
          db_cnt <= db_cnt + CNT_ONE;
          // Fire only on the step into saturation, so a held image is reported once.
          if (db_cnt == (CNT_MAX - CNT_ONE)) begin
            stable     <= snapshot;
            stable_upd <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: column strobing, row sampling, debounce and single-key events.
// Latency: a key held before a sweep starts gives key_valid ~DB_SCANS*4*SCAN_TICKS + 2 cycles later.
// Backpressure: none; key_valid is a one-cycle pulse, key_code holds until the next accepted key.
// Ports: clock, reset (async active-low), col (active-low one-hot strobes), row (active-low, async),
//        key_code (row*4+col of last accepted key), key_valid (accept pulse), key_held (in KEYDOWN).
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_TICKS = 1000,
  parameter int DB_SCANS   = 4
) (
  input  logic                clock,
  input  logic                reset,
  output logic [NUM_COLS-1:0] col,
  input  logic [NUM_ROWS-1:0] row,
  output logic [3:0]          key_code,
  output logic                key_valid,
  output logic                key_held
);

  localparam int            TW        = $clog2(SCAN_TICKS);
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [TW-1:0] TICK_ONE  = TW'(1);

  logic [NUM_ROWS-1:0] row_meta;
  logic [NUM_ROWS-1:0] row_sync;
  logic [TW-1:0]       tick;
  logic [1:0]          col_idx;
  logic [NUM_KEYS-1:0] snapshot;
  logic                sweep_end;
  logic [NUM_KEYS-1:0] stable;
  logic                stable_upd;
  kp_state_t           state;

  // Scanner. Sampling, column rotation and tick clear share the last-tick edge,
  // so every column is driven for exactly SCAN_TICKS cycles. sweep_end is raised
  // the cycle after column 3 is sampled so the debouncer sees the completed image.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      row_meta  <= '1;
      row_sync  <= '1;
      tick      <= '0;
      col_idx   <= '0;
      col       <= COL_RESET;
      snapshot  <= '0;
      sweep_end <= 1'b0;
    end else begin
      row_meta  <= row;
      row_sync  <= row_meta;
      sweep_end <= 1'b0;
      if (tick == TICK_LAST) begin
        snapshot[{col_idx, 2'b00} +: NUM_ROWS] <= ~row_sync;
        tick    <= '0;
        col_idx <= col_idx + 2'd1;
        col     <= {col[NUM_COLS-2:0], col[NUM_COLS-1]};
        if (col_idx == 2'd3) begin
          sweep_end <= 1'b1;
        end
      end else begin
        tick <= tick + TICK_ONE;
      end
    end
  end

  keypad_debounce #(
    .DB_SCANS (DB_SCANS)
  ) u_debounce (
    .clock      (clock),
    .reset      (reset),
    .snapshot   (snapshot),
    .sweep_end  (sweep_end),
    .stable     (stable),
    .stable_upd (stable_upd)
  );

  // Key state machine; only moves when a new debounced image arrives.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= NOKEY;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (stable_upd) begin
        case (state)
          NOKEY: begin
            if (is_single(stable)) begin
              key_code  <= image_to_code(stable);
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              state     <= KEYDOWN;
            end else if (stable != '0) begin
              state <= LOCKOUT;
            end
          end
          KEYDOWN: begin
            if (stable == '0) begin
              key_held <= 1'b0;
              state    <= NOKEY;
            end else if (!(is_single(stable) && image_to_code(stable) == key_code)) begin
              // The same key re-settling after a glitch is not a new press.
              key_held <= 1'b0;
              state    <= LOCKOUT;
            end
          end
          LOCKOUT: begin
            if (stable == '0) begin
              state <= NOKEY;
            end
          end
          default: begin
            key_held <= 1'b0;
            state    <= NOKEY;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan with a scoreboard of expected key events.
// A keypad model drives row from col; a sweep-level model predicts events.
module tb_keypad_scan;
  import keypad_scan_pkg::*;

  localparam int ST = 4;
  localparam int DB = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  // Pressed keys, bit index = row*4 + col (i.e. the key code).
  bit [15:0] pressed = '0;

  always #5 clock = ~clock;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  keypad_scan #(.SCAN_TICKS(ST), .DB_SCANS(DB)) dut (
    .clock     (clock),
    .reset     (reset),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Cycles since reset release; read at negedges only.
  int cyc;
  always @(posedge clock or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int last_valid_cyc = -1;

  typedef struct {
    int code;
    int at;
  } exp_t;
  exp_t exp_q[$];

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // ---------------- reference model (one evaluation per sweep) ----------------
  bit [15:0] m_img, m_prev;
  int m_cnt, m_mode, m_code;  // m_mode: 0 idle, 1 key down, 2 locked out

  task automatic model_reset();
    m_img = '0; m_prev = '0; m_cnt = 0; m_mode = 0; m_code = 0;
    exp_q.delete();
  endtask

  task automatic model_accept(input int m);
    int n, code;
    n = $countones(m_img);
    code = 0;
    for (int k = 0; k < 16; k++) if (m_img[k]) code = k;
    case (m_mode)
      0: if (n == 1) begin
           exp_t e;
           e.code = code; e.at = m + 5;
           exp_q.push_back(e);
           m_mode = 1; m_code = code;
         end else if (n >= 2) m_mode = 2;
      1: if (n == 0) m_mode = 0;
         else if (!(n == 1 && code == m_code)) m_mode = 2;
      default: if (n == 0) m_mode = 0;
    endcase
  endtask

  // Column c is seen by the DUT through the row level present in cycle 4c+1 of a sweep.
  task automatic model_capture();
    int m, c;
    if (!reset) return;
    m = cyc;
    if (m % 4 == 1) begin
      c = (m / 4) % 4;
      for (int r = 0; r < 4; r++) m_img[r*4+c] = pressed[r*4+c];
    end
    if (m % 16 == 13) begin
      if (m_img == m_prev) begin
        if (m_cnt < DB - 1) begin
          m_cnt++;
          if (m_cnt == DB - 1) model_accept(m);
        end
      end else begin
        m_prev = m_img;
        m_cnt = 0;
      end
    end
  endtask

  task automatic hold(input bit [15:0] p, input int n);
    repeat (n) begin
      @(negedge clock);
      pressed = p;
      model_capture();
    end
  endtask

  // Reset low for n cycles with keys p held; checks the asynchronous reset values.
  task automatic do_reset(input bit [15:0] p, input int n);
    @(negedge clock);
    reset = 1'b0;
    pressed = p;
    model_reset();
    #1;
    check("rst_col", col, 4'b1110);
    check("rst_key_code", key_code, 0);
    check("rst_key_valid", key_valid, 0);
    check("rst_key_held", key_held, 0);
    repeat (n) @(negedge clock);
    pressed = p;
    reset = 1'b1;
    model_capture();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (reset) begin
      logic [3:0] ec;
      ec = ~(4'b0001 << ((cyc / 4) % 4));
      check("col_strobe", col, ec);
      if (key_valid) begin
        pulses++;
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_key_valid: got code %0d at cycle %0d, expected no event", key_code, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("event_code", key_code, e.code);
          check_range("event_cycle", cyc, e.at - 1, e.at + 1);
          check("held_at_event", key_held, 1);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam bit [15:0] K3  = 16'h1 << 3;
  localparam bit [15:0] K4  = 16'h1 << 4;
  localparam bit [15:0] K5  = 16'h1 << 5;
  localparam bit [15:0] K7  = 16'h1 << 7;
  localparam bit [15:0] K9  = 16'h1 << 9;
  localparam bit [15:0] K14 = 16'h1 << 14;

  initial begin
    int p0;
    model_reset();
    repeat (3) @(negedge clock);
    check("init_col", col, 4'b1110);
    check("init_key_code", key_code, 0);
    check("init_key_valid", key_valid, 0);
    check("init_key_held", key_held, 0);
    @(negedge clock);
    reset = 1'b1;
    model_capture();

    // 1: idle scanning.
    hold('0, 64);
    check("s1_no_valid", pulses, 0);

    // 2: key 9 held from reset release.
    do_reset(K9, 2);
    p0 = pulses;
    hold(K9, 70);
    check("s2_one_pulse", pulses - p0, 1);
    check_range("s2_latency", last_valid_cyc, 46, 50);
    check("s2_code", key_code, 9);
    check("s2_held", key_held, 1);
    hold('0, 66);
    check("s2_released", key_held, 0);
    check("s2_code_kept", key_code, 9);

    // 3: key 3 bouncing, then held.
    p0 = pulses;
    for (int i = 0; i < 40; i++) hold(((i / 5) % 2 == 0) ? K3 : 16'h0, 1);
    check("s3_no_pulse_bounce", pulses - p0, 0);
    hold(K3, 70);
    check("s3_one_pulse", pulses - p0, 1);
    check("s3_code", key_code, 3);
    hold('0, 70);

    // 4: two keys together lock out; release re-arms.
    p0 = pulses;
    hold(K4 | K14, 80);
    check("s4_no_pulse_multi", pulses - p0, 0);
    check("s4_lockout", int'(dut.state), int'(LOCKOUT));
    check("s4_not_held", key_held, 0);
    hold('0, 70);
    hold(K4, 70);
    check("s4_one_pulse", pulses - p0, 1);
    check("s4_code", key_code, 4);
    p0 = pulses;
    hold(K4 | K5, 70);
    hold(K4, 70);
    check("s4_no_rearm_without_release", pulses - p0, 0);
    hold('0, 70);
    hold(K4, 70);
    check("s4_rearmed", pulses - p0, 1);
    check("s4_rearm_held", key_held, 1);

    // 5: reset mid-sweep with key held.
    do_reset(K7, 2);
    hold(K7, 30);
    do_reset(K7, 3);
    p0 = pulses;
    hold(K7, 70);
    check("s5_one_pulse", pulses - p0, 1);
    check("s5_code", key_code, 7);
    check_range("s5_latency", last_valid_cyc, 46, 50);
    hold('0, 70);

    // Random key patterns against the model.
    for (int round = 0; round < 12; round++) begin
      bit [15:0] p;
      int kind;
      kind = $urandom_range(0, 3);
      p = '0;
      if (kind == 1 || kind == 2) p[$urandom_range(0, 15)] = 1'b1;
      if (kind == 3) begin
        p[$urandom_range(0, 15)] = 1'b1;
        p[$urandom_range(0, 15)] = 1'b1;
      end
      hold(p, $urandom_range(20, 90));
    end
    hold('0, 80);
    check("no_missing_events", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
